// File: rtl/dmem_line_port.sv
// Backing data memory that serves whole cache lines over valid/ready request and response channels.
// Define DMEM_CRITICAL_WORD_FIRST_EN to start read bursts at the requested word and wrap within the line.
module dmem_line_port #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LINE_WORDS  = 4,
  parameter int LATENCY     = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_write,
  input  logic [ADDR_W-1:0]                 req_addr,
  input  logic [DATA_W*LINE_WORDS-1:0]      req_wdata,
  input  logic [(DATA_W/8)*LINE_WORDS-1:0]  req_wstrb,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic [DATA_W-1:0]                 resp_data,
  output logic [$clog2(LINE_WORDS)-1:0]     resp_idx,
  output logic                              resp_last,
  output logic                              resp_err
);

  localparam int BYTES  = DATA_W / 8;
  localparam int LW_W   = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int BOFF_W = $clog2(BYTES);
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  state_t                           state;
  logic [CNT_W-1:0]                 lat_cnt;
  logic                             wr_q;
  logic                             err_q;
  logic [IDX_W-1:0]                 base_q;
  logic [DATA_W*LINE_WORDS-1:0]     wdata_q;
  logic [BYTES*LINE_WORDS-1:0]      wstrb_q;
  logic [LW_W-1:0]                  start_idx;
  logic [LW_W-1:0]                  last_idx;
  logic [LW_W-1:0]                  next_idx;
  logic [ADDR_W-1:0]                word_addr;
  logic                             req_err;
  logic [IDX_W-1:0]                 req_base;
  logic                             accept;
  logic                             commit;

  // The whole word address takes part in the range check, so stray upper bits flag an error.
  assign word_addr = req_addr >> BOFF_W;
  assign req_err   = word_addr >= ADDR_W'(DEPTH_WORDS);
  assign req_base  = word_addr[IDX_W-1:0] & ~IDX_W'(LINE_WORDS - 1);
  assign accept    = req_valid && req_ready;
  assign commit    = (state == S_WAIT) && (lat_cnt == '0) && wr_q && !err_q;
  assign last_idx  = start_idx - LW_W'(1);
  assign next_idx  = resp_idx + LW_W'(1);

`ifdef DMEM_CRITICAL_WORD_FIRST_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_idx <= '0;
    end else if (accept) begin
      start_idx <= word_addr[LW_W-1:0];
    end
  end
`else
  assign start_idx = '0;
`endif

  function automatic logic [DATA_W-1:0] rd_word(input logic [LW_W-1:0] idx);
    return err_q ? '0 : mem[base_q | IDX_W'(idx)];
  endfunction

  // NOTE: storage has no reset so it maps onto RAM; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int w = 0; w < LINE_WORDS; w++) begin
        for (int b = 0; b < BYTES; b++) begin
          if (wstrb_q[w*BYTES + b]) begin
            mem[base_q | IDX_W'(w)][b*8 +: 8] <= wdata_q[(w*BYTES + b)*8 +: 8];
          end
        end
      end
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      lat_cnt    <= '0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      base_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_idx   <= '0;
      resp_last  <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state     <= S_WAIT;
            req_ready <= 1'b0;
            lat_cnt   <= CNT_W'(LATENCY - 1);
            wr_q      <= req_write;
            err_q     <= req_err;
            base_q    <= req_base;
            wdata_q   <= req_wdata;
            wstrb_q   <= req_wstrb;
          end
        end
        S_WAIT: begin
          if (lat_cnt == '0) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= err_q;
            if (wr_q) begin
              resp_data <= '0;
              resp_idx  <= '0;
              resp_last <= 1'b1;
            end else begin
              resp_data <= rd_word(start_idx);
              resp_idx  <= start_idx;
              resp_last <= (start_idx == last_idx);
            end
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            if (resp_last) begin
              state      <= S_IDLE;
              req_ready  <= 1'b1;
              resp_valid <= 1'b0;
              resp_data  <= '0;
              resp_idx   <= '0;
              resp_last  <= 1'b0;
              resp_err   <= 1'b0;
            end else begin
              resp_data <= rd_word(next_idx);
              resp_idx  <= next_idx;
              resp_last <= (next_idx == last_idx);
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_line_port.md
Name: dmem_line_port

Overview:
Parametrised backing data memory that serves whole cache lines to the data cache over a valid/ready request channel and a valid/ready response channel.
- Models fixed main-memory access latency with a counter.
- Returns read lines as a multi-beat burst, one word per beat.
- Writes full lines with per-word byte enables.
- Flags out-of-range accesses.

Parameters:
DATA_W, 32, bits per word (multiple of 8)
ADDR_W, 32, byte-address width
DEPTH_WORDS, 1024, storage depth in words (multiple of LINE_WORDS)
LINE_WORDS, 4, words per cache line (power of 2, >=2)
LATENCY, 4, cycles from request acceptance to first response (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_write  in  1  1=line write, 0=line read
req_addr  in  ADDR_W  byte address; offset bits below line size ignored except in optional mode
req_wdata  in  DATA_W*LINE_WORDS  write line; word 0 in LSBs
req_wstrb  in  (DATA_W/8)*LINE_WORDS  byte enables for req_wdata
resp_valid  out  1  response beat valid
resp_ready  in  1  consumer accepts beat
resp_data  out  DATA_W  read beat data (zero on write ack)
resp_idx  out  log2(LINE_WORDS)  word index within line of current beat
resp_last  out  1  final beat of response
resp_err  out  1  address out of range (held for all beats of that response)

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_last=0, resp_err=0, resp_data=0, resp_idx=0, counters 0.
- Storage is not reset; contents survive reset.
- Accept: on a clk edge with req_valid&&req_ready, capture req_write, line base, wdata, wstrb, and err.
  - Line base = word index with low log2(LINE_WORDS) bits cleared.
  - err = word index >= DEPTH_WORDS.
  - Go to WAIT; req_ready=0 from that edge until return to IDLE (one outstanding request).
- WAIT: latency counter loads LATENCY-1 at accept and decrements each cycle; at 0 go to RESP. resp_valid first asserts LATENCY cycles after the accept edge.
- RESP, read:
  - Beats 0..LINE_WORDS-1 in order; each beat holds until resp_valid&&resp_ready.
  - resp_last=1 on the final beat; after it is accepted, go to IDLE and req_ready=1 the next cycle.
  - resp_data is registered; the next beat can be presented the cycle after a handshake, so full throughput is one beat per cycle.
- RESP, write:
  - Memory is updated on the accept edge of WAIT's final cycle. Each word is written bytewise per wstrb; a zero strobe leaves that byte unchanged.
  - Then a single ack beat: resp_valid=1, resp_last=1, resp_data=0, resp_idx=0.
- Error:
  - err read returns all-zero beats with resp_err=1.
  - err write modifies nothing; ack carries resp_err=1.
- Read-after-write: a read accepted after a write's ack observes the written data.
- Backpressure: resp_ready low stalls the burst indefinitely; resp_data, resp_idx and resp_last stay stable while stalled.
- Requests presented while req_ready=0 are ignored; the requester must hold them.
- Reset mid-operation: any in-flight request is discarded and the FSM returns to IDLE.
  - A write not yet committed is lost.
  - A write already committed stays in storage.
  - No further beats are issued.
- Address width rule: addresses wider than needed are compared in full for the range check (upper bits nonzero gives err).

Optional Feature:
Macro DMEM_CRITICAL_WORD_FIRST_EN.
- Defined:
  - Read burst starts at the requested word (req_addr word offset) and wraps modulo LINE_WORDS.
  - resp_idx reports the actual word index of each beat.
  - resp_last is on the beat before the wrap returns to the start word.
- Undefined: bursts always start at index 0 and the offset bits are ignored.
- Writes and error handling are identical in both builds.

Test Plan:
- Reset, then idle for 3 cycles -> req_ready=1, resp_valid=0, resp_err=0, resp_last=0.
- Write line at 0x40 with data {0x44,0x33,0x22,0x11} and all strobes set; then read 0x40 with resp_ready=1 -> ack arrives 4 cycles after accept; read beats arrive on consecutive cycles, idx 0..3, data 0x11,0x22,0x33,0x44, resp_last on beat 3.
- Write 0x40, word 1 only, wstrb byte0 only, data 0xAB -> later read word1=0x000000AB (was 0x22), others unchanged.
- Read 0x40 with resp_ready toggling 1,0,0,1,... -> each beat is held stable while stalled; all 4 beats are delivered in order; req_ready returns 1 only after beat 3 is accepted.
- Read 0x1000 with DEPTH_WORDS=1024 -> 4 beats of 0 with resp_err=1. Write 0x1000 -> ack with resp_err=1; 0x1000 aliases word 0, and a read of 0x0 shows no change.
- Assert reset 2 cycles into WAIT of a write -> outputs return to reset values and the target line is unchanged. With DMEM_CRITICAL_WORD_FIRST_EN defined, read 0x48 -> idx 2,3,0,1 with last on idx 1.
